// File: rtl/uart_pkg.sv
// uart_pkg: receiver/transmitter shared state encoding, default bit timing and helpers
package uart_pkg;
  localparam int CPB_DEFAULT = 26;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_t;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small byte FIFO; pushes into a full FIFO are dropped unless a pop frees a slot that cycle
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty = cnt == '0;
  assign full = cnt == (AW + 1)'(DEPTH);
  assign dout = mem[rp];
  // storage, pointers and occupancy; memory is cleared so the head reads zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wp] <= din;
      wp <= do_push ? wp + AW'(1) : wp;
      rp <= do_pop ? rp + AW'(1) : rp;
      cnt <= cnt + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with input synchronizer, error pulses and receive FIFO
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CPB        = CPB_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam logic [7:0] HALF = 8'(CPB / 2 - 1);
  localparam logic [7:0] FULL = 8'(CPB - 1);
  uart_state_t state, state_n;
  logic [1:0] sync;
  logic rxs;
  logic [7:0] cnt, cnt_n, sh, sh_n;
  logic [2:0] bit_idx, bit_n;
  logic push, ferr, empty, full, pop;
  assign rxs = sync[1];
  assign rx_valid = !empty;
  assign pop = rx_valid && rx_ready;
  assign busy = state != IDLE;
  // synchronizer, FSM registers and registered error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync <= {sync[0], rx_in};
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      sh <= sh_n;
      frame_err <= ferr;
      overrun <= push && full && !pop;
    end
  end
  // next state: half-bit wait to centre on the start bit, then one sample per bit time
  always_comb begin
    state_n = state;
    cnt_n = sat_inc(cnt);
    bit_n = bit_idx;
    sh_n = sh;
    push = 1'b0;
    ferr = 1'b0;
    case (state)
      IDLE: if (!rxs) begin
        state_n = START;
        cnt_n = '0;
        bit_n = '0;
      end
      START: if (cnt == HALF) begin
        state_n = rxs ? IDLE : DATA;
        cnt_n = '0;
      end
      DATA: if (cnt == FULL) begin
        sh_n = {rxs, sh[7:1]};
        bit_n = bit_idx + 3'd1;
        cnt_n = '0;
        state_n = (bit_idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt == FULL) begin
        push = rxs;
        ferr = !rxs;
        cnt_n = '0;
        state_n = rxs ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: if (rxs) begin
        state_n = IDLE;
        cnt_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (sh),
    .pop  (pop),
    .dout (rx_data),
    .empty(empty),
    .full (full)
  );
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: scenario tasks with randomized frames against a queue-based reference
module tb_uart_rx_buffered;
  localparam int CPB = 26;
  localparam int DEPTH = 4;
  localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;
  logic clk = 1'b0, rst = 1'b1, rx_in = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
  int checks = 0, passed = 0;
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0;
  logic [7:0] got[$];

  uart_rx_buffered #(.CPB(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // consumer side observation, between edges
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got.push_back(rx_data);
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low);
    rx_in = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      step(CPB);
    end
    if (stop_low > 0) begin
      rx_in = 1'b0;
      step(CPB * stop_low);
    end
    rx_in = 1'b1;
    step(CPB);
  endtask

  task automatic test_reset;
    step(3);
    checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else passed++;
    checks++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", overrun); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    rst = 1'b0;
    step(5);
  endtask

  task automatic test_back_to_back;
    int g0 = got.size(), f0 = fe_cnt, o0 = ov_cnt;
    logic [7:0] exp_q[$] = '{8'h55, 8'hA3};
    rx_ready = 1'b1;
    send_frame(8'h55, 0);
    send_frame(8'hA3, 0);
    step(5);
    checks++; if (got.size() - g0 !== exp_q.size()) $display("FAIL b2b_count: got %0d want %0d", got.size() - g0, exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
      checks++; if (got[g0 + i] !== exp_q[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, got[g0 + i], exp_q[i]); else passed++;
    end
    checks++; if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) $display("FAIL b2b_errs: got fe=%0d ov=%0d want 0", fe_cnt - f0, ov_cnt - o0); else passed++;
  endtask

  task automatic test_glitch;
    int g0 = got.size(), f0 = fe_cnt;
    logic seen_busy;
    rx_in = 1'b0;
    step(5);
    seen_busy = busy;
    step(5);
    rx_in = 1'b1;
    step(14);
    checks++; if (seen_busy !== 1'b1) $display("FAIL glitch_busy_rise: got %b want 1", seen_busy); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL glitch_busy_fall: got %b want 0", busy); else passed++;
    checks++; if (got.size() - g0 !== 0 || fe_cnt - f0 !== 0) $display("FAIL glitch_quiet: got bytes=%0d fe=%0d want 0", got.size() - g0, fe_cnt - f0); else passed++;
    step(CPB);
  endtask

  task automatic test_frame_error;
    int g0 = got.size(), f0 = fe_cnt, o0 = ov_cnt;
    send_frame(8'h3C, 2);
    step(CPB);
    checks++; if (fe_cnt - f0 !== 1) $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - f0); else passed++;
    checks++; if (got.size() - g0 !== 0) $display("FAIL ferr_nobyte: got %0d want 0", got.size() - g0); else passed++;
    send_frame(8'h81, 0);
    step(5);
    checks++; if (got.size() - g0 !== 1) $display("FAIL ferr_next_count: got %0d want 1", got.size() - g0); else passed++;
    if (got.size() > g0) begin
      checks++; if (got[g0] !== 8'h81) $display("FAIL ferr_next_byte: got %h want 81", got[g0]); else passed++;
    end
    checks++; if (ov_cnt - o0 !== 0 || fe_cnt - f0 !== 1) $display("FAIL ferr_totals: got fe=%0d ov=%0d want 1,0", fe_cnt - f0, ov_cnt - o0); else passed++;
  endtask

  task automatic test_overrun(input int n, input logic randomize);
    int g0 = got.size(), o0 = ov_cnt;
    logic [7:0] sent[$];
    logic [7:0] b;
    int keep;
    rx_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = randomize ? 8'($urandom) : 8'(i + 1);
      sent.push_back(b);
      send_frame(b, 0);
    end
    step(3);
    keep = (n < DEPTH) ? n : DEPTH;
    checks++; if (ov_cnt - o0 !== n - keep) $display("FAIL ovr_pulses_n%0d: got %0d want %0d", n, ov_cnt - o0, n - keep); else passed++;
    checks++; if (got.size() - g0 !== 0) $display("FAIL ovr_held: got %0d want 0", got.size() - g0); else passed++;
    rx_ready = 1'b1;
    step(DEPTH + 4);
    checks++; if (got.size() - g0 !== keep) $display("FAIL ovr_drain_count: got %0d want %0d", got.size() - g0, keep); else passed++;
    for (int i = 0; i < keep && g0 + i < got.size(); i++) begin
      checks++; if (got[g0 + i] !== sent[i]) $display("FAIL ovr_drain%0d: got %h want %h", i, got[g0 + i], sent[i]); else passed++;
    end
  endtask

  task automatic test_full_with_pop;
    int g0 = got.size(), o0 = ov_cnt;
    logic [7:0] exp_q[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};
    rx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_frame(exp_q[i], 0);
    fork
      send_frame(8'h5A, 0);
      begin
        step(STOP_EDGE - 1);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
      end
    join
    checks++; if (ov_cnt - o0 !== 0) $display("FAIL fullpop_ovr: got %0d want 0", ov_cnt - o0); else passed++;
    checks++; if (got.size() - g0 !== 1) $display("FAIL fullpop_single: got %0d want 1", got.size() - g0); else passed++;
    rx_ready = 1'b1;
    step(DEPTH + 4);
    checks++; if (got.size() - g0 !== exp_q.size()) $display("FAIL fullpop_count: got %0d want %0d", got.size() - g0, exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
      checks++; if (got[g0 + i] !== exp_q[i]) $display("FAIL fullpop_byte%0d: got %h want %h", i, got[g0 + i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_reset_mid_frame;
    int g0 = got.size(), f0 = fe_cnt;
    logic [4:0] outs;
    fork
      send_frame(8'hFF, 0);
      begin
        step(5 * CPB + CPB / 2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        outs = {rx_valid, frame_err, overrun, busy, |rx_data};
      end
    join
    checks++; if (outs !== 5'b0) $display("FAIL midrst_outputs: got %b want 00000", outs); else passed++;
    step(CPB);
    checks++; if (got.size() - g0 !== 0 || fe_cnt - f0 !== 0) $display("FAIL midrst_nobyte: got bytes=%0d fe=%0d want 0", got.size() - g0, fe_cnt - f0); else passed++;
    send_frame(8'h42, 0);
    step(5);
    checks++; if (got.size() - g0 !== 1) $display("FAIL midrst_next_count: got %0d want 1", got.size() - g0); else passed++;
    if (got.size() > g0) begin
      checks++; if (got[g0] !== 8'h42) $display("FAIL midrst_next_byte: got %h want 42", got[g0]); else passed++;
    end
  endtask

  task automatic test_random_stream;
    int g0 = got.size(), f0 = fe_cnt, o0 = ov_cnt;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 0);
      step($urandom_range(1, 40));
    end
    checks++; if (got.size() - g0 !== exp_q.size()) $display("FAIL rand_count: got %0d want %0d", got.size() - g0, exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
      checks++; if (got[g0 + i] !== exp_q[i]) $display("FAIL rand_byte%0d: got %h want %h", i, got[g0 + i], exp_q[i]); else passed++;
    end
    checks++; if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) $display("FAIL rand_errs: got fe=%0d ov=%0d want 0", fe_cnt - f0, ov_cnt - o0); else passed++;
    checks++; if (both_cnt !== 0) $display("FAIL err_exclusive: got %0d want 0", both_cnt); else passed++;
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_glitch;
    test_frame_error;
    test_overrun(5, 1'b0);
    test_full_with_pop;
    test_reset_mid_frame;
    test_random_stream;
    test_overrun($urandom_range(1, 7), 1'b1);
    test_overrun($urandom_range(1, 7), 1'b1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
